// File: rtl/bin_fb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bin_fb_pkg : shared types/constants for the binned frame buffer  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package bin_fb_pkg;

  localparam int BIN_HRES_DEF = 320;
  localparam int BIN_VRES_DEF = 180;
  localparam int FRAME_PIX    = BIN_HRES_DEF * BIN_VRES_DEF;
  localparam int AW           = $clog2(FRAME_PIX);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    WR_SYNC  = 2'd0,
    WR_WRITE = 2'd1,
    WR_SKIP  = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_READ  = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/bin_fb_rd_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bin_fb_rd_seq : streams one granted bank out, one pixel/cycle     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module bin_fb_rd_seq
  import bin_fb_pkg::*;
#(
  parameter int FRAME_N = FRAME_PIX,
  parameter int ADDR_W  = AW
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            grant_i,
  input  logic            grant_bank_i,
  input  logic            rd_data_i,
  output logic            idle_o,
  output logic [ADDR_W:0] rd_addr_o,
  output logic            frame_ack_o,
  output logic            pix_o,
  output logic            pix_valid_o,
  output logic            frame_done_o,
  output logic            release_o,
  output logic            release_bank_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_N - 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              bank_q, bank_d;
  logic              ack_q, ack_d;
  logic              drain_q, drain_d;
  logic              done_q, done_d;
  logic [1:0]        vld_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bank_d  = bank_q;
    ack_d   = 1'b0;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        if (grant_i) begin
          state_d = RD_READ;
          addr_d  = '0;
          bank_d  = grant_bank_i;
          ack_d   = 1'b1;
        end
      end
      RD_READ: begin
        if (addr_q == LAST_ADDR) begin
          state_d = RD_DRAIN;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      RD_DRAIN: begin
        // two cycles lets the last BRAM word emerge before the bank is freed
        if (drain_q) begin
          state_d = RD_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= RD_IDLE;
      addr_q  <= '0;
      bank_q  <= 1'b0;
      ack_q   <= 1'b0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bank_q  <= bank_d;
      ack_q   <= ack_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      vld_q   <= {vld_q[0], (state_q == RD_READ)};
    end
  end

  assign idle_o         = (state_q == RD_IDLE);
  assign rd_addr_o      = {bank_q, addr_q};
  assign frame_ack_o    = ack_q;
  assign pix_valid_o    = vld_q[1];
  assign pix_o          = vld_q[1] & rd_data_i;
  assign frame_done_o   = done_q;
  assign release_o      = done_q;
  assign release_bank_o = bank_q;

endmodule
`default_nettype wire

// File: rtl/bin_frame_pingpong_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bin_frame_pingpong_ctrl : two-bank frame store write/grant control|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module bin_frame_pingpong_ctrl
  import bin_fb_pkg::*;
#(
  parameter  int BIN_HRES = 320,
  parameter  int BIN_VRES = 180,
  localparam int FRAME_N  = BIN_HRES * BIN_VRES,
  localparam int ADDR_W   = $clog2(FRAME_N),
  localparam int H_W      = $clog2(BIN_HRES),
  localparam int V_W      = $clog2(BIN_VRES)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            bin_valid_in,
  input  logic [H_W-1:0]  bin_hcount_in,
  input  logic [V_W-1:0]  bin_vcount_in,
  input  logic            bin_pixel_in,
  output logic            wr_en_out,
  output logic [ADDR_W:0] wr_addr_out,
  output logic            wr_data_out,
  input  logic            frame_req_in,
  output logic            frame_ack_out,
  output logic [ADDR_W:0] rd_addr_out,
  input  logic            rd_data_in,
  output logic            pix_out,
  output logic            pix_valid_out,
  output logic            frame_done_out,
  output logic [15:0]     drop_count_out
);

  bank_state_t       st_q [2];
  bank_state_t       st_d [2];
  wr_state_t         wr_state_q, wr_state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              newest_q, newest_d;
  logic [15:0]       drop_q, drop_d;
  logic              wen_d, tgt_bank;
  logic              wr_en_q, wr_data_q;
  logic [ADDR_W:0]   wr_addr_q;
  logic [ADDR_W-1:0] lin_addr;
  logic              beat_ok, beat_origin, beat_last;
  logic              grant, grant_bank, rd_idle, rd_release, rd_release_bank;

  // widened compares keep the range check meaningful for power-of-two sizes
  assign beat_ok     = bin_valid_in
                     && ({1'b0, bin_hcount_in} < (H_W+1)'(BIN_HRES))
                     && ({1'b0, bin_vcount_in} < (V_W+1)'(BIN_VRES));
  assign beat_origin = beat_ok && (bin_hcount_in == '0) && (bin_vcount_in == '0);
  assign beat_last   = beat_ok && (bin_hcount_in == H_W'(BIN_HRES - 1))
                                && (bin_vcount_in == V_W'(BIN_VRES - 1));
  assign lin_addr    = ADDR_W'(bin_vcount_in) * ADDR_W'(BIN_HRES) + ADDR_W'(bin_hcount_in);

  assign grant      = rd_idle && frame_req_in
                    && ((st_q[0] == BANK_FULL) || (st_q[1] == BANK_FULL));
  assign grant_bank = (st_q[newest_q] == BANK_FULL) ? newest_q : ~newest_q;

  always_comb begin
    st_d       = st_q;
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    newest_d   = newest_q;
    drop_d     = drop_q;
    wen_d      = 1'b0;
    tgt_bank   = wr_bank_q;
    // reader and writer only ever touch banks in disjoint states
    if (rd_release) st_d[rd_release_bank] = BANK_EMPTY;
    if (grant) begin
      st_d[grant_bank] = BANK_READING;
      if (st_q[~grant_bank] == BANK_FULL) st_d[~grant_bank] = BANK_EMPTY;
    end
    unique case (wr_state_q)
      WR_SYNC, WR_SKIP: begin
        if (beat_origin) begin
          if ((st_q[0] == BANK_EMPTY) || (st_q[1] == BANK_EMPTY)) begin
            tgt_bank       = (st_q[0] == BANK_EMPTY) ? 1'b0 : 1'b1;
            wr_bank_d      = tgt_bank;
            st_d[tgt_bank] = BANK_WRITING;
            wen_d          = 1'b1;
            wr_state_d     = WR_WRITE;
          end else begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            wr_state_d = WR_SKIP;
          end
        end
      end
      WR_WRITE: begin
        if (beat_ok) begin
          wen_d = 1'b1;
          if (beat_last) begin
            st_d[wr_bank_q] = BANK_FULL;
            newest_d        = wr_bank_q;
            wr_state_d      = (st_q[~wr_bank_q] == BANK_EMPTY) ? WR_SYNC : WR_SKIP;
          end
        end
      end
      default: wr_state_d = WR_SYNC;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st_q[0]    <= BANK_EMPTY;
      st_q[1]    <= BANK_EMPTY;
      wr_state_q <= WR_SYNC;
      wr_bank_q  <= 1'b0;
      newest_q   <= 1'b0;
      drop_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_state_q <= wr_state_d;
      wr_bank_q  <= wr_bank_d;
      newest_q   <= newest_d;
      drop_q     <= drop_d;
      wr_en_q    <= wen_d;
      if (wen_d) begin
        wr_addr_q <= {tgt_bank, lin_addr};
        wr_data_q <= bin_pixel_in;
      end
    end
  end

  assign wr_en_out      = wr_en_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign drop_count_out = drop_q;

  bin_fb_rd_seq #(
    .FRAME_N (FRAME_N),
    .ADDR_W  (ADDR_W)
  ) u_rd_seq (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .grant_i        (grant),
    .grant_bank_i   (grant_bank),
    .rd_data_i      (rd_data_in),
    .idle_o         (rd_idle),
    .rd_addr_o      (rd_addr_out),
    .frame_ack_o    (frame_ack_out),
    .pix_o          (pix_out),
    .pix_valid_o    (pix_valid_out),
    .frame_done_o   (frame_done_out),
    .release_o      (rd_release),
    .release_bank_o (rd_release_bank)
  );

endmodule
`default_nettype wire

// File: tb/tb_bin_frame_pingpong_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bin_frame_pingpong_ctrl : 4x3 frame bench with bank-level model|
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_bin_frame_pingpong_ctrl;

  localparam int HR = 4;
  localparam int VR = 3;
  localparam int HW = 2;
  localparam int VW = 2;
  localparam int NPIX = HR * VR;
  localparam int BANK_STRIDE = 16;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b1;
  logic          bin_valid_in = 1'b0;
  logic [HW-1:0] bin_hcount_in = '0;
  logic [VW-1:0] bin_vcount_in = '0;
  logic          bin_pixel_in = 1'b0;
  logic          frame_req_in = 1'b0;
  logic          wr_en_out, wr_data_out, frame_ack_out, rd_data_in;
  logic          pix_out, pix_valid_out, frame_done_out;
  logic [4:0]    wr_addr_out, rd_addr_out;
  logic [15:0]   drop_count_out;

  bin_frame_pingpong_ctrl #(.BIN_HRES(HR), .BIN_VRES(VR)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .bin_valid_in(bin_valid_in), .bin_hcount_in(bin_hcount_in),
    .bin_vcount_in(bin_vcount_in), .bin_pixel_in(bin_pixel_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .frame_req_in(frame_req_in), .frame_ack_out(frame_ack_out),
    .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
    .pix_out(pix_out), .pix_valid_out(pix_valid_out),
    .frame_done_out(frame_done_out), .drop_count_out(drop_count_out)
  );

  initial forever #5 clk_in = ~clk_in;

  // external frame-store BRAM: port-B read with 2-cycle latency
  logic mem [32];
  logic rd_p1 = 1'b0, rd_p2 = 1'b0;
  initial for (int i = 0; i < 32; i++) mem[i] = 1'b0;
  always @(posedge clk_in) begin
    if (wr_en_out) mem[wr_addr_out] <= wr_data_out;
    rd_p1 <= mem[rd_addr_out];
    rd_p2 <= rd_p1;
  end
  assign rd_data_in = rd_p2;

  int errors = 0;
  int checks = 0;

  // bank-level reference: 0 empty, 1 writing, 2 full, 3 reading
  int m_st [2];
  int m_wbank, m_newest, m_drop;
  bit exp_img [2][NPIX];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st[0] = 0; m_st[1] = 0; m_wbank = -1; m_newest = 0; m_drop = 0;
  endtask

  task automatic model_beat(input bit vld, input int h, input int v, input bit p,
                            output bit e_en, output int e_addr);
    e_en = 1'b0; e_addr = 0;
    if (!vld || h >= HR || v >= VR) return;
    if (m_wbank < 0) begin
      if (h != 0 || v != 0) return;
      if (m_st[0] == 0) m_wbank = 0;
      else if (m_st[1] == 0) m_wbank = 1;
      else begin
        if (m_drop < 65535) m_drop++;
        return;
      end
      m_st[m_wbank] = 1;
    end
    e_en = 1'b1;
    e_addr = m_wbank * BANK_STRIDE + v * HR + h;
    exp_img[m_wbank][v * HR + h] = p;
    if (h == HR - 1 && v == VR - 1) begin
      m_st[m_wbank] = 2; m_newest = m_wbank; m_wbank = -1;
    end
  endtask

  task automatic model_grant(output int gb);
    gb = 0;
    if (m_st[0] != 2 && m_st[1] != 2) return;
    gb = (m_st[m_newest] == 2) ? m_newest : 1 - m_newest;
    m_st[gb] = 3;
    if (m_st[1 - gb] == 2) m_st[1 - gb] = 0;
  endtask

  task automatic beat(input bit vld, input int h, input int v, input bit p);
    bit e_en; int e_addr;
    @(negedge clk_in);
    bin_valid_in = vld; bin_hcount_in = HW'(h); bin_vcount_in = VW'(v); bin_pixel_in = p;
    model_beat(vld, h, v, p, e_en, e_addr);
    @(posedge clk_in); #1;
    check($sformatf("wr_en(%0d,%0d)", h, v), 32'(wr_en_out), 32'(e_en));
    if (e_en) begin
      check($sformatf("wr_addr(%0d,%0d)", h, v), 32'(wr_addr_out), 32'(e_addr));
      check($sformatf("wr_data(%0d,%0d)", h, v), 32'(wr_data_out), 32'(p));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in); bin_valid_in = 1'b0;
      @(posedge clk_in); #1;
      check("wr_en_idle", 32'(wr_en_out), 32'd0);
    end
  endtask

  task automatic send_frame(input bit noisy, input int restart_len);
    int r;
    for (int i = 0; i < restart_len; i++) beat(1'b1, i % HR, i / HR, 1'($urandom_range(0, 1)));
    for (int i = 0; i < NPIX; i++) begin
      r = int'($urandom_range(0, 3));
      if (noisy && r == 0) beat(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1);
      if (noisy && r == 1) beat(1'b1, int'($urandom_range(0, 3)), 3, 1'b1);
      beat(1'b1, i % HR, i / HR, 1'($urandom_range(0, 1)));
    end
  endtask

  // entered #1 after the edge at which the grant should have registered
  task automatic read_frame(input int gb, input int abort_at);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin @(posedge clk_in); #1; end
      check($sformatf("ack k%0d", k), 32'(frame_ack_out), 32'(k == 0));
      if (k < NPIX) check($sformatf("rd_addr k%0d", k), 32'(rd_addr_out), 32'(gb * BANK_STRIDE + k));
      check($sformatf("pix_valid k%0d", k), 32'(pix_valid_out), 32'(k >= 2 && k <= NPIX + 1));
      if (k >= 2 && k <= NPIX + 1)
        check($sformatf("pix k%0d", k), 32'(pix_out), 32'(exp_img[gb][k - 2]));
      check($sformatf("done k%0d", k), 32'(frame_done_out), 32'(k == NPIX + 2));
      if (k == abort_at) begin
        #2 rst_n_in = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en_out), 32'd0);
        check("rst_wr_addr", 32'(wr_addr_out), 32'd0);
        check("rst_rd_addr", 32'(rd_addr_out), 32'd0);
        check("rst_pix_valid", 32'(pix_valid_out), 32'd0);
        check("rst_pix", 32'(pix_out), 32'd0);
        check("rst_drop", 32'(drop_count_out), 32'd0);
        model_reset();
        return;
      end
      if (k == 0) begin
        @(negedge clk_in); frame_req_in = 1'b0; bin_valid_in = 1'b0;
      end
    end
    m_st[gb] = 0;
  endtask

  task automatic request_and_read(input int abort_at);
    int gb;
    @(negedge clk_in);
    frame_req_in = 1'b1; bin_valid_in = 1'b0;
    model_grant(gb);
    @(posedge clk_in); #1;
    read_frame(gb, abort_at);
  endtask

  initial begin
    int gb; bit e_en; int e_addr; bit p;
    model_reset();
    #2 rst_n_in = 1'b0;
    #1;
    check("reset_wr_en", 32'(wr_en_out), 32'd0);
    check("reset_wr_addr", 32'(wr_addr_out), 32'd0);
    check("reset_ack", 32'(frame_ack_out), 32'd0);
    check("reset_rd_addr", 32'(rd_addr_out), 32'd0);
    check("reset_pix_valid", 32'(pix_valid_out), 32'd0);
    check("reset_done", 32'(frame_done_out), 32'd0);
    check("reset_drop", 32'(drop_count_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;

    // no completed frame: a request must not be granted
    frame_req_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      check("no_full_ack", 32'(frame_ack_out), 32'd0);
    end
    @(negedge clk_in); frame_req_in = 1'b0;

    // beats before the first origin (incl. the last pixel and an out-of-range row)
    beat(1'b1, 2, 1, 1'b1);
    beat(1'b1, 1, 0, 1'b1);
    beat(1'b1, 3, 2, 1'b1);
    beat(1'b1, 0, 3, 1'b1);
    send_frame(1'b0, 0);
    idle(1);
    request_and_read(-1);

    // three frames, no consumer: third origin is dropped
    send_frame(1'b1, 3);
    send_frame(1'b1, 0);
    send_frame(1'b1, 0);
    idle(1);
    check("drop_after_3_frames", 32'(drop_count_out), 32'(m_drop));
    check("drop_is_one", 32'(drop_count_out), 32'd1);
    request_and_read(-1);
    send_frame(1'b1, 0);
    idle(1);

    // completion of bank 1 coincides with a request while bank 0 is full
    for (int i = 0; i < NPIX - 1; i++) beat(1'b1, i % HR, i / HR, 1'($urandom_range(0, 1)));
    @(negedge clk_in);
    p = 1'($urandom_range(0, 1));
    bin_valid_in = 1'b1; bin_hcount_in = HW'(HR - 1); bin_vcount_in = VW'(VR - 1);
    bin_pixel_in = p; frame_req_in = 1'b1;
    model_grant(gb);
    model_beat(1'b1, HR - 1, VR - 1, p, e_en, e_addr);
    @(posedge clk_in); #1;
    check("sim_wr_en", 32'(wr_en_out), 32'(e_en));
    check("sim_wr_addr", 32'(wr_addr_out), 32'(e_addr));
    check("sim_wr_data", 32'(wr_data_out), 32'(p));
    read_frame(gb, -1);

    // reset in the middle of a read
    request_and_read(5);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); #1;
      check("post_rst_done", 32'(frame_done_out), 32'd0);
      check("post_rst_pix_valid", 32'(pix_valid_out), 32'd0);
    end

    // both banks must be free again: two frames land without a drop
    send_frame(1'b1, 0);
    send_frame(1'b1, 0);
    idle(1);
    check("post_rst_drop", 32'(drop_count_out), 32'(m_drop));
    request_and_read(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bin_frame_pingpong_ctrl.md
# bin_frame_pingpong_ctrl

Ping-pong frame-buffer controller for the 4×4 binned mask stream. It converts binned (hcount, vcount, pixel) beats into write addresses for a two-bank BRAM frame store, and tracks each bank as EMPTY, WRITING, FULL or READING. It grants whole completed frames to a single downstream consumer (centroid/display) that reads one pixel per cycle. It sits between the binning stage and the frame-store BRAM; the BRAM itself is external.

## Interface
Parameters:
- BIN_HRES, 320, binned columns per frame
- BIN_VRES, 180, binned rows per frame
- Derived: AW = $clog2(BIN_HRES*BIN_VRES), HW = $clog2(BIN_HRES), VW = $clog2(BIN_VRES)

Ports:
- clk_in  in  1  system clock; one clock domain
- rst_n_in  in  1  reset, asynchronous, active-low
- bin_valid_in  in  1  binned beat valid
- bin_hcount_in  in  HW  binned column
- bin_vcount_in  in  VW  binned row
- bin_pixel_in  in  1  binned mask bit
- wr_en_out  out  1  frame-store write enable
- wr_addr_out  out  AW+1  {bank, vcount*BIN_HRES+hcount}
- wr_data_out  out  1  write data
- frame_req_in  in  1  consumer requests a frame (level)
- frame_ack_out  out  1  one-cycle grant pulse
- rd_addr_out  out  AW+1  {bank, linear address}
- rd_data_in  in  1  frame-store port-B data, 2-cycle latency
- pix_out  out  1  read pixel
- pix_valid_out  out  1  pix_out valid
- frame_done_out  out  1  one-cycle pulse after the last pixel
- drop_count_out  out  16  frames discarded; saturating

## Operation
- Bank state: st[0..1] ∈ {EMPTY, WRITING, FULL, READING}. `newest` is the most recently completed bank.
- Writer FSM: SYNC, WRITE, SKIP.
  - SYNC (after reset): beats are discarded until a valid beat at (0,0). On that beat, claim an EMPTY bank (lowest index first) and mark it WRITING. Go to WRITE and write the beat.
  - WRITE: every valid beat is written. A beat at (BIN_HRES-1, BIN_VRES-1) marks the bank FULL and sets `newest` to it.
    - If the other bank is EMPTY, go to SYNC.
    - Otherwise go to SKIP.
  - SKIP: beats are discarded. On each (0,0) beat, if a bank is EMPTY, claim it and write that beat (go to WRITE). If no bank is EMPTY, drop_count increments and SKIP is held.
  - A (0,0) beat seen in WRITE before frame end is a restart. Keep the same bank, reset nothing else, and write the beat.
  - Beats with hcount ≥ BIN_HRES or vcount ≥ BIN_VRES are ignored.
- Reader FSM: IDLE, READ, DRAIN.
  - IDLE: if frame_req_in=1 and any bank is FULL:
    - pulse frame_ack_out;
    - mark `newest` READING;
    - if the other bank is also FULL, set it to EMPTY;
    - enter READ at address 0.
  - READ: rd_addr increments once per cycle up to BIN_HRES*BIN_VRES-1, then enter DRAIN.
  - DRAIN: 2 cycles. Then pulse frame_done_out, set the bank to EMPTY, and return to IDLE.
- Simultaneous events: both FSMs evaluate registered bank state. A frame completion and a grant in the same cycle resolve with the grant seeing the pre-completion state. The completion and any EMPTY release both commit; they never target the same bank.

## Timing
- Write path latency is 1 cycle: a beat at cycle t produces wr_en/wr_addr/wr_data registered at t+1. The address multiply is registered once.
- Read path: pix_valid_out/pix_out follow rd_addr_out by exactly 2 cycles. pix_valid_out is high for exactly BIN_HRES*BIN_VRES consecutive cycles. frame_done_out coincides with the cycle after the last pix_valid_out.
- The first rd_addr (0) is presented in the same cycle as frame_ack_out.
- Reset values: all outputs 0; st = {EMPTY, EMPTY}; writer in SYNC; reader in IDLE; newest = 0; drop_count = 0.
- Reset asserted mid-frame aborts both FSMs immediately. No partial frame is ever marked FULL.
- drop_count saturates at 16'hFFFF.

## Structure
- Package bin_fb_pkg holds:
  - bank_state_t enum;
  - writer/reader FSM state enums;
  - localparams FRAME_PIX and AW, computed from BIN_HRES/BIN_VRES defaults.
- One sub-module, bin_fb_rd_seq: the reader FSM, address counter and 2-stage valid/done pipeline. It receives a grant and bank, and returns a release pulse.
- The bank-state table and writer FSM live in the top.

## Test plan
- Reset, then one full 4×3 frame (BIN_HRES=4, BIN_VRES=3) starting at (0,0) -> 12 writes to bank 0 at addrs 0..11; st[0]=FULL; writer in SYNC.
- Beats at (2,1) before any (0,0) after reset -> wr_en_out stays 0 until the (0,0) beat.
- frame_req_in high with bank 0 FULL -> frame_ack_out at t, rd_addr {0,0}..{0,11}, pix_valid_out t+2..t+13 matching the written data, frame_done_out at t+14, st[0]=EMPTY.
- Three frames written with no request -> third (0,0) finds both banks FULL; drop_count=1. A request then reads `newest` and frees the other bank; the next (0,0) writes to the freed bank.
- Frame completion in the same cycle as frame_req_in with only the other bank FULL -> grant reads the other bank; the completing bank becomes FULL; no data corruption.
- rst_n_in pulled low mid-READ at address 5 -> all outputs 0 asynchronously; after release, both banks are EMPTY and no frame_done_out is issued.
